mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: DATA_BASE, default 1024, lowest byte address of the data region; stores below it are rejected.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  core requests an access.
REQ-005 req_ready  output  1  controller can accept a request.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I width code: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu (loads); 000 sb, 001 sh, 010 sw (stores).
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-justified.
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-012 rsp_err  output  1  access rejected; qualified by rsp_valid.
REQ-013 mem_addr  output  32  word-aligned address to the unified memory.
REQ-014 mem_wdata  output  32  full-word write data.
REQ-015 mem_we  output  1  word write strobe, sampled by memory at posedge clk.
REQ-016 mem_rdata  input  32  combinational memory read data, little-endian.

Function
REQ-017 FSM states SHALL be IDLE, READ, WRITE, RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 On req_valid in IDLE the controller SHALL latch addr, we, funct3, wdata; next state: READ for loads and sub-word stores, WRITE for sw, RESP for errors.
REQ-019 mem_addr SHALL equal {latched_addr[31:2],2'b00} in READ and WRITE, and 0 otherwise.
REQ-020 READ SHALL capture mem_rdata; loads go to RESP, sub-word stores go to WRITE.
REQ-021 Load extraction: byte lane addr[1:0], halfword lane addr[1]; lb/lh sign-extend, lbu/lhu zero-extend, lw passes through.
REQ-022 Sub-word store SHALL merge req_wdata[7:0] or [15:0] into the captured word at the addressed lane; other bytes unchanged.
REQ-023 mem_we SHALL be 1 for exactly one cycle in WRITE and 0 in every other state.
REQ-024 RESP SHALL assert rsp_valid for one cycle and return to IDLE; no response back-pressure.
REQ-025 Latency, accept-cycle to rsp_valid: load 2 cycles, sw 2 cycles, sb/sh 3 cycles, error 1 cycle.
REQ-026 Errors (rsp_err=1, no mem_we): halfword with addr[0]=1; word with addr[1:0]!=0; store to addr<DATA_BASE; reserved funct3 (011, 110, 111; store funct3 1xx).
REQ-027 req_valid outside IDLE SHALL be ignored; requests are never queued.

Reset
REQ-028 While reset=1, the FSM SHALL be IDLE and req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_addr=0, mem_wdata=0, mem_we=0.
REQ-029 Reset mid-operation SHALL abort with no mem_we pulse and no rsp_valid; the memory word keeps its prior value.

Configuration
REQ-030 Macro MEM_ACCESS_SUBWORD_EN: when defined, byte/halfword loads and stores behave per REQ-021/022.
REQ-031 When not defined, only funct3=010 is legal; any other funct3 is an error per REQ-026, and the READ-merge path for stores SHALL be absent.

Structure
REQ-032 Shared package mem_pkg SHALL hold the FSM state enum, funct3 width constants and DATA_BASE default.
REQ-033 Sub-module mem_lane_align SHALL be combinational: load extraction/extension and store merge.

Verification
REQ-034 Memory word at 0x400 = 0x8081F2A5; lb addr 0x401 -> rsp_rdata 0xFFFFFFF2 two cycles after accept; lbu addr 0x401 -> 0x000000F2.
REQ-035 Same word; sh 0xBEEF to 0x402 -> READ, one mem_we pulse with mem_wdata 0xBEEFF2A5 at mem_addr 0x400, rsp_valid on the third cycle.
REQ-036 sw 0x12345678 to 0x404 -> mem_we in the cycle after accept, no READ state; a following lw 0x404 returns 0x12345678.
REQ-037 lw 0x402 -> rsp_err=1, rsp_rdata=0, one cycle after accept; sw to 0x0010 -> rsp_err=1 with mem_we never asserted.
REQ-038 Assert reset during the WRITE cycle of an sb to 0x408 -> no mem_we pulse, word at 0x408 unchanged, all outputs at reset values.
REQ-039 With MEM_ACCESS_SUBWORD_EN undefined, lh 0x400 -> rsp_err=1; lw 0x400 succeeds.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg -- shared definitions for the memory access controller.
//
// Holds the controller FSM state encoding, the RV32I load/store width codes,
// the default lowest byte address of the writable data region, and the
// request legality check used when a request is accepted.
//
// Build option: define MEM_ACCESS_SUBWORD_EN to make byte and halfword
// accesses legal. Without it, only word accesses (funct3 = 010) are accepted.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] DATA_BASE_DEFAULT = 32'd1024;

    // Returns 1 when a request must be rejected: bad width code for its
    // direction, misaligned halfword/word, or a store below the data region.
    function automatic logic access_error(input logic        we,
                                          input logic [2:0]  funct3,
                                          input logic [31:0] addr,
                                          input logic [31:0] data_base);
        logic err;
        err = 1'b0;
`ifdef MEM_ACCESS_SUBWORD_EN
        case (funct3)
            F3_B:    err = 1'b0;
            F3_H:    err = addr[0];
            F3_W:    err = (addr[1:0] != 2'b00);
            F3_BU:   err = we;
            F3_HU:   err = we | addr[0];
            default: err = 1'b1;
        endcase
`else
        err = (funct3 != F3_W) || (addr[1:0] != 2'b00);
`endif
        if (we && (addr < data_base)) begin
            err = 1'b1;
        end
        return err;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align -- combinational byte-lane steering.
//
// Ports:
//   word       in  32  word read from memory (little-endian)
//   addr_lo    in   2  low byte-address bits of the access
//   funct3     in   3  RV32I width code of the access
//   wdata      in  32  right-justified store data
//   load_data  out 32  extracted and sign/zero-extended load result
//   store_word out 32  word to write back (sub-word merged into word)
//
// Build option: MEM_ACCESS_SUBWORD_EN enables lane extraction and merging;
// without it both outputs pass the full word straight through.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

`ifdef MEM_ACCESS_SUBWORD_EN
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];

        // funct3[2] selects zero extension (lbu/lhu).
        case (funct3[1:0])
            2'b00:   load_data = funct3[2] ? {24'd0, byte_sel}
                                           : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_data = funct3[2] ? {16'd0, half_sel}
                                           : {{16{half_sel[15]}}, half_sel};
            default: load_data = word;
        endcase

        store_word = word;
        case (funct3[1:0])
            2'b00: store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            2'b01: begin
                if (addr_lo[1]) begin
                    store_word[31:16] = wdata[15:0];
                end else begin
                    store_word[15:0] = wdata[15:0];
                end
            end
            default: store_word = wdata;
        endcase
    end
`else
    // Word-only build: lane selection is meaningless, so these are sunk.
    logic unused_lane_bits;
    assign unused_lane_bits = ^{addr_lo, funct3};
    assign load_data  = word;
    assign store_word = wdata;
`endif

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl -- single-outstanding load/store controller between a core
// and a word-wide unified memory.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   req_valid/req_ready request handshake (see below)
//   req_we, req_funct3  store flag and RV32I width code
//   req_addr, req_wdata byte address and right-justified store data
//   rsp_valid           one-cycle completion pulse
//   rsp_rdata, rsp_err  extended load data (0 for stores/errors), reject flag
//   mem_addr            word-aligned memory address (0 outside READ/WRITE)
//   mem_wdata, mem_we   full-word write data and write strobe
//   mem_rdata           combinational memory read data
//   dbg_state           current FSM state (mem_pkg::state_t encoding)
//
// Handshake: a request is taken on a rising edge where req_valid and
// req_ready are both 1. req_ready is 1 only in IDLE; req_valid in any other
// state is ignored and nothing is queued. rsp_valid is a single-cycle pulse
// with no back-pressure; rsp_err and rsp_rdata are meaningful only with it.
//
// Build option: MEM_ACCESS_SUBWORD_EN enables byte/halfword accesses via a
// read-merge-write sequence for sub-word stores.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter logic [31:0] DATA_BASE = DATA_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  dbg_state
);

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        accept;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] store_word;

    assign accept  = (state_q == ST_IDLE) && req_valid;
    assign req_err = access_error(req_we, req_funct3, req_addr, DATA_BASE);

    mem_lane_align u_lane_align (
        .word       (mem_rdata),
        .addr_lo    (addr_q[1:0]),
        .funct3     (funct3_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            funct3_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q   <= req_addr;
                we_q     <= req_we;
                funct3_q <= req_funct3;
                wdata_q  <= req_wdata;
                err_q    <= req_err;
                // Cleared here so stores and errors respond with zero data.
                rdata_q  <= '0;
            end
            if (state_q == ST_READ) begin
                if (we_q) begin
                    wdata_q <= store_word;
                end else begin
                    rdata_q <= load_data;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err) begin
                        state_d = ST_RESP;
                    end else if (req_we && (req_funct3 == F3_W)) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                mem_addr = {addr_q[31:2], 2'b00};
`ifdef MEM_ACCESS_SUBWORD_EN
                state_d  = we_q ? ST_WRITE : ST_RESP;
`else
                state_d  = ST_RESP;
`endif
            end
            ST_WRITE: begin
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_wdata = wdata_q;
                mem_we    = 1'b1;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = rdata_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;
    import mem_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic [1:0]  dbg_state;

    mem_access_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .dbg_state  (dbg_state)
    );

    // ---------------- memory model ----------------
    logic [31:0] mem [0:511];
    int          we_cnt = 0;
    logic [22:0] unused_addr_bits;
    assign unused_addr_bits = {mem_addr[31:11], mem_addr[1:0]};
    assign mem_rdata = mem[mem_addr[10:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[10:2]] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;

    int          r_lat;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_read;
    int          r_wes;
    logic [31:0] r_waddr;
    logic [31:0] r_wdata;
    logic        r_timeout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Presents one request, then watches negedges until rsp_valid
    // (bounded), recording latency, response, READ visits and write pulses.
    task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd);
        int base;
        @(negedge clk);
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        base = we_cnt;
        r_read = 1'b0; r_lat = 0; r_timeout = 1'b0; r_rdata = '0; r_err = 1'b0;
        r_waddr = '0; r_wdata = '0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (dbg_state == ST_READ) r_read = 1'b1;
            if (mem_we) begin r_waddr = mem_addr; r_wdata = mem_wdata; end
            if (rsp_valid) begin
                r_lat = n; r_rdata = rsp_rdata; r_err = rsp_err;
                break;
            end
            if (n == 8) r_timeout = 1'b1;
        end
        r_wes = we_cnt - base;
        chk({tag, "_done"}, {31'd0, r_timeout}, 32'd0);
    endtask

    task automatic chk_rsp(input string tag, input int lat, input logic err,
                           input logic [31:0] rdata, input int wes);
        chk({tag, "_lat"},   r_lat, lat);
        chk({tag, "_err"},   {31'd0, r_err}, {31'd0, err});
        chk({tag, "_rdata"}, r_rdata, rdata);
        chk({tag, "_wes"},   r_wes, wes);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_rspv"},  {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_err"},   {31'd0, rsp_err}, 32'd0);
        chk({tag, "_maddr"}, mem_addr, 32'd0);
        chk({tag, "_mwdata"}, mem_wdata, 32'd0);
        chk({tag, "_mwe"},   {31'd0, mem_we}, 32'd0);
        chk({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        reset = 1'b0;

        // sw to 0x404: straight to WRITE, response two cycles after accept.
        run_req("sw404", 1'b1, F3_W, 32'h404, 32'h1234_5678);
        chk_rsp("sw404", 2, 1'b0, 32'd0, 1);
        chk("sw404_noread", {31'd0, r_read}, 32'd0);
        chk("sw404_waddr", r_waddr, 32'h404);
        chk("sw404_wdata", r_wdata, 32'h1234_5678);

        run_req("lw404", 1'b0, F3_W, 32'h404, 32'd0);
        chk_rsp("lw404", 2, 1'b0, 32'h1234_5678, 0);
        chk("lw404_read", {31'd0, r_read}, 32'd1);

        run_req("sw400", 1'b1, F3_W, 32'h400, 32'h8081_F2A5);
        chk_rsp("sw400", 2, 1'b0, 32'd0, 1);
        run_req("lw400", 1'b0, F3_W, 32'h400, 32'd0);
        chk_rsp("lw400", 2, 1'b0, 32'h8081_F2A5, 0);

        // Rejections respond one cycle after accept with no write.
        run_req("lw402", 1'b0, F3_W, 32'h402, 32'd0);
        chk_rsp("lw402", 1, 1'b1, 32'd0, 0);
        run_req("sw010", 1'b1, F3_W, 32'h10, 32'hDEAD_BEEF);
        chk_rsp("sw010", 1, 1'b1, 32'd0, 0);
        run_req("sw3fc", 1'b1, F3_W, 32'h3FC, 32'hDEAD_BEEF);
        chk_rsp("sw3fc", 1, 1'b1, 32'd0, 0);
        run_req("ld011", 1'b0, 3'b011, 32'h400, 32'd0);
        chk_rsp("ld011", 1, 1'b1, 32'd0, 0);
        run_req("st100", 1'b1, 3'b100, 32'h400, 32'd0);
        chk_rsp("st100", 1, 1'b1, 32'd0, 0);

`ifdef MEM_ACCESS_SUBWORD_EN
        run_req("lb401", 1'b0, F3_B, 32'h401, 32'd0);
        chk_rsp("lb401", 2, 1'b0, 32'hFFFF_FFF2, 0);
        run_req("lbu401", 1'b0, F3_BU, 32'h401, 32'd0);
        chk_rsp("lbu401", 2, 1'b0, 32'h0000_00F2, 0);
        run_req("lh402", 1'b0, F3_H, 32'h402, 32'd0);
        chk_rsp("lh402", 2, 1'b0, 32'hFFFF_8081, 0);
        run_req("lhu400", 1'b0, F3_HU, 32'h400, 32'd0);
        chk_rsp("lhu400", 2, 1'b0, 32'h0000_F2A5, 0);
        run_req("lh401", 1'b0, F3_H, 32'h401, 32'd0);
        chk_rsp("lh401", 1, 1'b1, 32'd0, 0);
        run_req("sh402", 1'b1, F3_H, 32'h402, 32'h0000_BEEF);
        chk_rsp("sh402", 3, 1'b0, 32'd0, 1);
        chk("sh402_read", {31'd0, r_read}, 32'd1);
        chk("sh402_waddr", r_waddr, 32'h400);
        chk("sh402_wdata", r_wdata, 32'hBEEF_F2A5);
        run_req("sb403", 1'b1, F3_B, 32'h403, 32'hFFFF_FF11);
        chk_rsp("sb403", 3, 1'b0, 32'd0, 1);
        run_req("lw400b", 1'b0, F3_W, 32'h400, 32'd0);
        chk_rsp("lw400b", 2, 1'b0, 32'h11EF_F2A5, 0);
`else
        run_req("lh400", 1'b0, F3_H, 32'h400, 32'd0);
        chk_rsp("lh400", 1, 1'b1, 32'd0, 0);
        run_req("lb401", 1'b0, F3_B, 32'h401, 32'd0);
        chk_rsp("lb401", 1, 1'b1, 32'd0, 0);
        run_req("sb408", 1'b1, F3_B, 32'h408, 32'h55);
        chk_rsp("sb408", 1, 1'b1, 32'd0, 0);
        run_req("lw400c", 1'b0, F3_W, 32'h400, 32'd0);
        chk_rsp("lw400c", 2, 1'b0, 32'h8081_F2A5, 0);
`endif

        // req_valid held high while busy must not start a second access.
        run_req("sw410", 1'b1, F3_W, 32'h410, 32'h55AA_55AA);
        chk_rsp("sw410", 2, 1'b0, 32'd0, 1);
        begin
            int base;
            logic seen;
            base = we_cnt;
            seen = 1'b0;
            @(negedge clk);
            req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h40C; req_wdata = 32'hA5A5_0001;
            @(posedge clk); #1;
            req_addr = 32'h410; req_wdata = 32'h0BAD_0BAD;
            for (int n = 1; n <= 8; n++) begin
                @(negedge clk);
                if (rsp_valid) begin seen = 1'b1; break; end
            end
            req_valid = 1'b0;
            chk("busy_rsp", {31'd0, seen}, 32'd1);
            chk("busy_wes", we_cnt - base, 32'd1);
        end
        run_req("lw410", 1'b0, F3_W, 32'h410, 32'd0);
        chk_rsp("lw410", 2, 1'b0, 32'h55AA_55AA, 0);
        run_req("lw40c", 1'b0, F3_W, 32'h40C, 32'd0);
        chk_rsp("lw40c", 2, 1'b0, 32'hA5A5_0001, 0);

        // Reset during the WRITE cycle of a store to 0x408.
        run_req("sw408", 1'b1, F3_W, 32'h408, 32'hCAFE_F00D);
        chk_rsp("sw408", 2, 1'b0, 32'd0, 1);
        begin
            int   base;
            logic in_write;
            logic seen;
            @(negedge clk);
            req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h408; req_wdata = 32'h1111_1111;
`ifdef MEM_ACCESS_SUBWORD_EN
            req_funct3 = F3_B;
`else
            req_funct3 = F3_W;
`endif
            @(posedge clk); #1;
            req_valid = 1'b0;
            in_write = 1'b0;
            for (int n = 1; n <= 8; n++) begin
                @(negedge clk);
                if (dbg_state == ST_WRITE) begin in_write = 1'b1; break; end
            end
            chk("abort_reached_write", {31'd0, in_write}, 32'd1);
            base = we_cnt;
            reset = 1'b1;
            #1;
            chk_reset_outputs("abort");
            @(negedge clk);
            chk("abort_wes", we_cnt - base, 32'd0);
            reset = 1'b0;
            seen = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (rsp_valid) seen = 1'b1;
            end
            chk("abort_no_rsp", {31'd0, seen}, 32'd0);
        end
        run_req("lw408", 1'b0, F3_W, 32'h408, 32'd0);
        chk_rsp("lw408", 2, 1'b0, 32'hCAFE_F00D, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
